id_ex_reg: RTL and testbench
============================

Name: id_ex_reg

Overview:
- ID/EX pipeline register of the 5-stage MIPS core.
- Sits directly downstream of the decode stage and the immediate-extension logic; captures the 32-bit extended immediate, register operands, register numbers, PC+4 and the decoded control bundle, then presents them to EX.
- Contains the load-use hazard detector; inserts bubbles on flush or load-use and holds on downstream stall.
- Counts inserted bubbles for performance monitoring.

Parameters:
- DW, 32, datapath width (PC, operands, immediate).
- RW, 5, register-number width.
- CNT_W, 16, bubble-counter width.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_pc_plus4  in  DW  PC+4 of ID instruction.
- id_rs_data  in  DW  register-file read data, rs.
- id_rt_data  in  DW  register-file read data, rt.
- id_imm_ext  in  DW  extended immediate (sign/zero/lui already applied).
- id_rs, id_rt, id_rd  in  RW each  register numbers.
- id_uses_rs, id_uses_rt  in  1 each  instruction actually reads rs/rt.
- id_reg_write, id_mem_read, id_mem_write, id_branch, id_alu_src  in  1 each  decoded controls.
- id_mem_to_reg, id_reg_dst  in  2 each  decoded selects.
- id_alu_op  in  5  ALU operation code.
- flush  in  1  kill ID instruction (branch/jump resolved in EX).
- hold  in  1  downstream stall; freeze ID/EX.
- ex_*  out  one registered copy of every id_* input above except id_uses_rs/id_uses_rt, same widths; includes ex_valid, ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm_ext, ex_rs, ex_rt, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_alu_src, ex_mem_to_reg, ex_reg_dst, ex_alu_op.
- stall_out  out  1  freeze PC and IF/ID (combinational).
- bubble_cnt  out  CNT_W  count of bubbles inserted, saturating.

Behaviour:
- Latency: 1 cycle from id_* to ex_* on a normal capture.
- Reset (synchronous): every ex_* output is 0 and bubble_cnt is 0. stall_out is combinational from the cleared state, so it evaluates to 0 unless hold=1.
- load_use (combinational) = ex_valid & ex_mem_read & (ex_rt != 0) & id_valid & ((id_uses_rs & ex_rt==id_rs) | (id_uses_rt & ex_rt==id_rt)).
- stall_out = (load_use | hold) & ~flush.
- Per-edge priority, highest first:
  1. reset: clear everything.
  2. flush: load a bubble.
  3. hold: keep all ex_* unchanged.
  4. load_use: load a bubble.
  5. otherwise: capture id_*.
- Bubble contents: ex_valid=0, all control bits and selects 0, data and register-number fields 0. A bubble must never write the register file or memory.
- Normal capture with id_valid=0: fields are copied as given, except that ex_reg_write, ex_mem_read, ex_mem_write and ex_branch are forced to 0.
- bubble_cnt increments by 1 on each edge that loads a bubble due to flush or load_use, and only when not in reset. It saturates at all-ones and does not wrap. hold does not count.
- Simultaneous flush+hold: flush wins, the register bubbles, and stall_out=0.
- Simultaneous flush+load_use: a single bubble, counted once.
- hold+load_use: contents are held, load_use remains true, and stall_out stays 1 for as long as either condition holds.
- A load-use stall lasts exactly one cycle. After the bubble, ex_mem_read=0, so load_use deasserts and the waiting instruction is captured on the next edge.
- Reset mid-stall or mid-hold: cleared on that edge; no residual stall.
- ex_imm_ext passes the 32-bit value bit-exact; no re-extension in this block.

Test Plan:
- Reset: assert reset 2 cycles with all inputs randomised -> every ex_* = 0, bubble_cnt = 0; stall_out = 0 whenever hold = 0.
- Normal capture: id_imm_ext=32'hFFFF_8000, id_rs_data=32'h1234_5678, id_reg_write=1, id_valid=1 -> exactly those values on ex_* one edge later; stall_out = 0.
- Load-use: EX holds lw with ex_rt=5; ID is add with id_rs=5, id_uses_rs=1 -> stall_out = 1 for one cycle, next ex_valid = 0, bubble_cnt = 1, add captured on the following edge. Repeat with ex_rt=0 -> no stall.
- Flush vs hold: flush=1 and hold=1 with a valid ID instruction -> ex_valid = 0 next edge, stall_out = 0, bubble_cnt += 1. hold alone for 3 cycles -> ex_* frozen, count unchanged.
- Saturation: preload via 65 540 forced flushes -> bubble_cnt = 16'hFFFF and stays there.
- Reset mid-hold: hold=1 with valid contents, pulse reset for one edge -> all ex_* = 0 and bubble_cnt = 0 on that edge.

Source files
------------

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use hazard detection and a saturating bubble counter.
// Latency: 1 cycle from id_* to ex_* on a normal capture.
// Backpressure: hold freezes ex_*; stall_out freezes PC and IF/ID on load-use or hold, unless flushing.
//
// Ports:
//   clk, reset                 core clock, synchronous active-high reset
//   id_*                       decoded instruction, operands and controls from ID
//   flush                      kill the ID instruction (bubble into EX)
//   hold                       downstream stall, keep EX contents
//   ex_*                       registered copy of the ID bundle presented to EX
//   stall_out                  freeze upstream stages (combinational)
//   bubble_cnt                 saturating count of inserted bubbles
module id_ex_reg #(
  parameter int DW    = 32,
  parameter int RW    = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [DW-1:0]    id_pc_plus4,
  input  logic [DW-1:0]    id_rs_data,
  input  logic [DW-1:0]    id_rt_data,
  input  logic [DW-1:0]    id_imm_ext,
  input  logic [RW-1:0]    id_rs,
  input  logic [RW-1:0]    id_rt,
  input  logic [RW-1:0]    id_rd,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             id_branch,
  input  logic             id_alu_src,
  input  logic [1:0]       id_mem_to_reg,
  input  logic [1:0]       id_reg_dst,
  input  logic [4:0]       id_alu_op,
  input  logic             flush,
  input  logic             hold,
  output logic             ex_valid,
  output logic [DW-1:0]    ex_pc_plus4,
  output logic [DW-1:0]    ex_rs_data,
  output logic [DW-1:0]    ex_rt_data,
  output logic [DW-1:0]    ex_imm_ext,
  output logic [RW-1:0]    ex_rs,
  output logic [RW-1:0]    ex_rt,
  output logic [RW-1:0]    ex_rd,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             ex_branch,
  output logic             ex_alu_src,
  output logic [1:0]       ex_mem_to_reg,
  output logic [1:0]       ex_reg_dst,
  output logic [4:0]       ex_alu_op,
  output logic             stall_out,
  output logic [CNT_W-1:0] bubble_cnt
);

  logic load_use;
  logic insert_bubble;

  // A load in EX whose destination is read by the ID instruction; $zero never hazards.
  assign load_use = ex_valid & ex_mem_read & (ex_rt != '0) & id_valid &
                    ((id_uses_rs & (ex_rt == id_rs)) | (id_uses_rt & (ex_rt == id_rt)));

  assign stall_out = (load_use | hold) & ~flush;

  // hold outranks load_use, so a held load-use does not bubble (or count) until hold drops.
  assign insert_bubble = flush | (~hold & load_use);

  always_ff @(posedge clk) begin
    if (reset || insert_bubble) begin
      ex_valid      <= 1'b0;
      ex_pc_plus4   <= '0;
      ex_rs_data    <= '0;
      ex_rt_data    <= '0;
      ex_imm_ext    <= '0;
      ex_rs         <= '0;
      ex_rt         <= '0;
      ex_rd         <= '0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_branch     <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_mem_to_reg <= '0;
      ex_reg_dst    <= '0;
      ex_alu_op     <= '0;
    end else if (!hold) begin
      ex_valid      <= id_valid;
      ex_pc_plus4   <= id_pc_plus4;
      ex_rs_data    <= id_rs_data;
      ex_rt_data    <= id_rt_data;
      ex_imm_ext    <= id_imm_ext;
      ex_rs         <= id_rs;
      ex_rt         <= id_rt;
      ex_rd         <= id_rd;
      // Architectural side effects are suppressed for a non-instruction.
      ex_reg_write  <= id_reg_write & id_valid;
      ex_mem_read   <= id_mem_read & id_valid;
      ex_mem_write  <= id_mem_write & id_valid;
      ex_branch     <= id_branch & id_valid;
      ex_alu_src    <= id_alu_src;
      ex_mem_to_reg <= id_mem_to_reg;
      ex_reg_dst    <= id_reg_dst;
      ex_alu_op     <= id_alu_op;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_cnt <= '0;
    end else if (insert_bubble && (bubble_cnt != {CNT_W{1'b1}})) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_reg.sv
module tb_id_ex_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [31:0] id_pc_plus4, id_rs_data, id_rt_data, id_imm_ext;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_uses_rs, id_uses_rt;
  logic        id_reg_write, id_mem_read, id_mem_write, id_branch, id_alu_src;
  logic [1:0]  id_mem_to_reg, id_reg_dst;
  logic [4:0]  id_alu_op;
  logic        flush, hold;

  logic        ex_valid;
  logic [31:0] ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm_ext;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_alu_src;
  logic [1:0]  ex_mem_to_reg, ex_reg_dst;
  logic [4:0]  ex_alu_op;
  logic        stall_out;
  logic [15:0] bubble_cnt;

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  id_ex_reg #(.DW(32), .RW(5), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_pc_plus4(id_pc_plus4), .id_rs_data(id_rs_data),
    .id_rt_data(id_rt_data), .id_imm_ext(id_imm_ext),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_branch(id_branch), .id_alu_src(id_alu_src),
    .id_mem_to_reg(id_mem_to_reg), .id_reg_dst(id_reg_dst), .id_alu_op(id_alu_op),
    .flush(flush), .hold(hold),
    .ex_valid(ex_valid), .ex_pc_plus4(ex_pc_plus4), .ex_rs_data(ex_rs_data),
    .ex_rt_data(ex_rt_data), .ex_imm_ext(ex_imm_ext),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_branch(ex_branch), .ex_alu_src(ex_alu_src),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_dst(ex_reg_dst), .ex_alu_op(ex_alu_op),
    .stall_out(stall_out), .bubble_cnt(bubble_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge, outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_id();
    id_valid = 0; id_pc_plus4 = 0; id_rs_data = 0; id_rt_data = 0; id_imm_ext = 0;
    id_rs = 0; id_rt = 0; id_rd = 0; id_uses_rs = 0; id_uses_rt = 0;
    id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_branch = 0; id_alu_src = 0;
    id_mem_to_reg = 0; id_reg_dst = 0; id_alu_op = 0;
  endtask

  task automatic rand_id();
    id_valid = 1'($urandom); id_pc_plus4 = $urandom; id_rs_data = $urandom;
    id_rt_data = $urandom; id_imm_ext = $urandom;
    id_rs = 5'($urandom); id_rt = 5'($urandom); id_rd = 5'($urandom);
    id_uses_rs = 1'($urandom); id_uses_rt = 1'($urandom);
    id_reg_write = 1'($urandom); id_mem_read = 1'($urandom); id_mem_write = 1'($urandom);
    id_branch = 1'($urandom); id_alu_src = 1'($urandom);
    id_mem_to_reg = 2'($urandom); id_reg_dst = 2'($urandom); id_alu_op = 5'($urandom);
    flush = 1'($urandom);
  endtask

  initial begin
    // ---------------- reset with random inputs ----------------
    reset = 1; hold = 0; flush = 0;
    rand_id();
    tick();
    rand_id(); hold = 0;
    #1;
    chk("rst_stall", stall_out, 0);
    tick();
    chk("rst_valid", ex_valid, 0);
    chk("rst_pc", ex_pc_plus4, 0);
    chk("rst_rs_data", ex_rs_data, 0);
    chk("rst_imm", ex_imm_ext, 0);
    chk("rst_rt", ex_rt, 0);
    chk("rst_ctrl", {ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_alu_src,
                     ex_mem_to_reg, ex_reg_dst, ex_alu_op}, 0);
    chk("rst_cnt", bubble_cnt, 0);

    // ---------------- normal capture ----------------
    reset = 0; flush = 0; hold = 0;
    clear_id();
    id_valid = 1; id_imm_ext = 32'hFFFF_8000; id_rs_data = 32'h1234_5678; id_reg_write = 1;
    #1;
    chk("cap_stall", stall_out, 0);
    tick();
    chk("cap_valid", ex_valid, 1);
    chk("cap_imm", ex_imm_ext, 32'hFFFF_8000);
    chk("cap_rs_data", ex_rs_data, 32'h1234_5678);
    chk("cap_reg_write", ex_reg_write, 1);
    chk("cap_mem_read", ex_mem_read, 0);

    // ---------------- load-use on rt=5 ----------------
    clear_id();
    id_valid = 1; id_mem_read = 1; id_reg_write = 1; id_rt = 5; id_rs = 3;
    id_mem_to_reg = 1; id_alu_src = 1; id_pc_plus4 = 32'h40;
    tick();
    chk("lw_mem_read", ex_mem_read, 1);
    chk("lw_rt", ex_rt, 5);
    clear_id();
    id_valid = 1; id_rs = 5; id_uses_rs = 1; id_rt = 6; id_uses_rt = 1; id_rd = 7;
    id_reg_write = 1; id_alu_op = 5'h02; id_pc_plus4 = 32'h44;
    #1;
    chk("lu_stall", stall_out, 1);
    tick();
    chk("lu_bubble_valid", ex_valid, 0);
    chk("lu_bubble_rw", ex_reg_write, 0);
    chk("lu_cnt", bubble_cnt, 1);
    chk("lu_stall_gone", stall_out, 0);
    tick();
    chk("lu_add_valid", ex_valid, 1);
    chk("lu_add_rd", ex_rd, 7);
    chk("lu_add_pc", ex_pc_plus4, 32'h44);
    chk("lu_cnt_same", bubble_cnt, 1);

    // ---------------- load to $zero: no hazard ----------------
    clear_id();
    id_valid = 1; id_mem_read = 1; id_rt = 0;
    tick();
    clear_id();
    id_valid = 1; id_rs = 0; id_uses_rs = 1; id_rd = 8; id_reg_write = 1;
    #1;
    chk("z_stall", stall_out, 0);
    tick();
    chk("z_valid", ex_valid, 1);
    chk("z_rd", ex_rd, 8);
    chk("z_cnt", bubble_cnt, 1);

    // ---------------- id_valid=0 capture suppresses side effects ----------------
    clear_id();
    id_valid = 0; id_reg_write = 1; id_mem_write = 1; id_branch = 1; id_mem_read = 1;
    id_rd = 12; id_alu_op = 5'h11;
    tick();
    chk("nv_ctrl", {ex_reg_write, ex_mem_read, ex_mem_write, ex_branch}, 0);
    chk("nv_rd", ex_rd, 12);
    chk("nv_alu_op", ex_alu_op, 5'h11);

    // ---------------- flush + hold ----------------
    clear_id();
    id_valid = 1; id_rd = 4; id_reg_write = 1;
    flush = 1; hold = 1;
    #1;
    chk("fh_stall", stall_out, 0);
    tick();
    chk("fh_valid", ex_valid, 0);
    chk("fh_rd", ex_rd, 0);
    chk("fh_cnt", bubble_cnt, 2);

    // ---------------- hold alone for 3 cycles ----------------
    flush = 0; hold = 0;
    clear_id();
    id_valid = 1; id_rd = 9; id_pc_plus4 = 32'h100; id_reg_write = 1;
    tick();
    clear_id();
    id_valid = 1; id_rd = 10; id_pc_plus4 = 32'h104;
    hold = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_stall", stall_out, 1);
      chk("hold_rd", ex_rd, 9);
      chk("hold_pc", ex_pc_plus4, 32'h100);
      chk("hold_cnt", bubble_cnt, 2);
    end

    // ---------------- reset mid-hold ----------------
    reset = 1;
    tick();
    reset = 0;
    chk("rh_valid", ex_valid, 0);
    chk("rh_rd", ex_rd, 0);
    chk("rh_pc", ex_pc_plus4, 0);
    chk("rh_cnt", bubble_cnt, 0);
    chk("rh_stall_hold", stall_out, 1);
    hold = 0;
    #1;
    chk("rh_stall_free", stall_out, 0);

    // ---------------- saturation ----------------
    clear_id();
    id_valid = 1;
    flush = 1;
    repeat (65534) tick();
    chk("sat_fffe", bubble_cnt, 16'hFFFE);
    tick();
    chk("sat_ffff", bubble_cnt, 16'hFFFF);
    repeat (5) tick();
    chk("sat_hold", bubble_cnt, 16'hFFFF);
    flush = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
